// File: rtl/fp_conv_pkg.sv
// Shared types and helpers for the integer-to-minifloat converter.
package fp_conv_pkg;

    typedef enum logic [1:0] {
        RM_TRUNC     = 2'b00,
        RM_HALF_UP   = 2'b01,
        RM_HALF_EVEN = 2'b10,
        RM_RSVD      = 2'b11
    } rmode_e;

    function automatic int unsigned e_max_of(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational bit-length counter: position of the highest set bit plus one, 0 for zero.
module fp_lzc #(
    parameter int unsigned W  = 12,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [LW-1:0] len_o
);

    always_comb begin
        len_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (data_i[i]) len_o = LW'(i + 1);
        end
    end

endmodule

// File: rtl/fp_convert_pipe.sv
// Three-stage streaming signed-integer to (S, E, F) mini-float converter with
// selectable rounding, saturation flags and a sticky saturation counter.
module fp_convert_pipe
    import fp_conv_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned EXP_W  = 3,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [FRAC_W-1:0] out_f,
    output logic              out_ovf,
    output logic              out_inexact,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    localparam int unsigned LZW   = $clog2(DATA_W + 1);
    localparam int unsigned XW    = (LZW >= EXP_W) ? LZW + 1 : EXP_W + 1;
    localparam int unsigned E_MAX = e_max_of(EXP_W);

    // Stage registers
    logic              v1_q, v2_q, v3_q;
    logic              s1_q, s2_q;
    logic [DATA_W-1:0] mag1_q, mag2_q;
    rmode_e            rm1_q, rm2_q;
    logic [LZW-1:0]    eraw2_q;
    logic              out_s_q, out_ovf_q, out_inexact_q;
    logic [EXP_W-1:0]  out_e_q;
    logic [FRAC_W-1:0] out_f_q;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

    logic ready2, ready3, adv2, adv3;

    assign adv3     = v3_q && out_ready;
    assign ready3   = !v3_q || out_ready;
    assign adv2     = v2_q && ready3;
    assign ready2   = !v2_q || adv2;
    assign in_ready = !v1_q || ready2;

    // Stage 1: sign/magnitude capture
    logic [DATA_W-1:0] mag_d;
    assign mag_d = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            mag1_q <= '0;
            rm1_q  <= RM_TRUNC;
        end else if (in_ready) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q   <= in_data[DATA_W-1];
                mag1_q <= mag_d;
                rm1_q  <= rmode_e'(in_rmode);
            end
        end
    end

    // Stage 2: normalise
    logic [LZW-1:0] len1;
    logic [LZW-1:0] eraw_d;

    fp_lzc #(.W(DATA_W), .LW(LZW)) u_lzc (
        .data_i (mag1_q),
        .len_o  (len1)
    );

    assign eraw_d = (len1 > LZW'(FRAC_W)) ? (len1 - LZW'(FRAC_W)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            mag2_q  <= '0;
            rm2_q   <= RM_TRUNC;
            eraw2_q <= '0;
        end else if (ready2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_q    <= s1_q;
                mag2_q  <= mag1_q;
                rm2_q   <= rm1_q;
                eraw2_q <= eraw_d;
            end
        end
    end

    // Stage 3: round and pack
    logic [FRAC_W-1:0] kept;
    logic [DATA_W-1:0] stk_mask;
    logic              guard, sticky, inc, ovf;
    logic [FRAC_W:0]   sum;
    logic [XW-1:0]     exp_w;
    logic [FRAC_W-1:0] f_d;
    logic [EXP_W-1:0]  e_d;

    always_comb begin
        kept     = '0;
        stk_mask = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        inc      = 1'b0;
        sum      = '0;
        exp_w    = '0;
        f_d      = mag2_q[FRAC_W-1:0];
        if (eraw2_q != '0) begin
            kept     = FRAC_W'(mag2_q >> eraw2_q);
            guard    = |(mag2_q & (DATA_W'(1) << (eraw2_q - LZW'(1))));
            stk_mask = (DATA_W'(1) << (eraw2_q - LZW'(1))) - DATA_W'(1);
            sticky   = |(mag2_q & stk_mask);
            case (rm2_q)
                RM_HALF_UP:   inc = guard;
                RM_HALF_EVEN: inc = guard & (sticky | kept[0]);
                default:      inc = 1'b0;
            endcase
            sum   = {1'b0, kept} + {{FRAC_W{1'b0}}, inc};
            exp_w = XW'(eraw2_q) + XW'(sum[FRAC_W]);
            f_d   = sum[FRAC_W] ? {1'b1, {(FRAC_W-1){1'b0}}} : sum[FRAC_W-1:0];
        end
        ovf = exp_w > XW'(E_MAX);
        e_d = exp_w[EXP_W-1:0];
        if (ovf) begin
            e_d = '1;
            f_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q          <= 1'b0;
            out_s_q       <= 1'b0;
            out_e_q       <= '0;
            out_f_q       <= '0;
            out_ovf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (ready3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                out_s_q       <= s2_q;
                out_e_q       <= e_d;
                out_f_q       <= f_d;
                out_ovf_q     <= ovf;
                out_inexact_q <= guard | sticky | ovf;
            end
        end
    end

    // Clear takes priority over a coincident saturated delivery
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (adv3 && out_ovf_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign out_valid   = v3_q;
    assign out_s       = out_s_q;
    assign out_e       = out_e_q;
    assign out_f       = out_f_q;
    assign out_ovf     = out_ovf_q;
    assign out_inexact = out_inexact_q;
    assign sat_cnt     = sat_cnt_q;

endmodule
